// File: rtl/frame_diff_tracker.sv
// Raster-scanning cell tracker with an on-chip previous frame.
// Reports per-cell object codes, change flags and per-frame change counts.
module frame_diff_tracker #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12,
    parameter int NUM_OBJ = 4,
    parameter int CODE_W  = 3,
    parameter int CNT_W   = 8,
    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_OBJ-1:0] obj_in,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CODE_W-1:0]  obj_code,
    output logic               diff,
    output logic               out_valid,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic               frame_done,
    output logic [CNT_W-1:0]   diff_count
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    logic [CODE_W-1:0] mem [CELLS];
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] old_code;
    logic [AW-1:0]     addr;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_next;
    logic              first_frame;
    logic              cell_diff;
    logic              last_cell;
    logic              advance;

    // Highest set flag wins; no flag means an empty cell.
    always_comb begin
        code = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (obj_in[i]) begin
                code = CODE_W'(i + 1);
            end
        end
    end

    // Cell lookup against the stored frame and saturating count update.
    always_comb begin
        addr      = AW'(y) * AW'(GRID_W) + AW'(x);
        old_code  = mem[addr];
        cell_diff = (code != old_code) && !first_frame;
        last_cell = (x == X_LAST) && (y == Y_LAST);
        advance   = enable && !clear;
        run_next  = run_cnt;
        if (cell_diff && (run_cnt != {CNT_W{1'b1}})) begin
            run_next = run_cnt + CNT_W'(1);
        end
    end

    // Frame store: contents are masked by first_frame, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && advance) begin
            mem[addr] <= code;
        end
    end

    // Scan position, registered cell report and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            obj_code    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            diff        <= 1'b0;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
            diff_count  <= '0;
            run_cnt     <= '0;
            first_frame <= 1'b1;
        end else if (clear) begin
            x           <= '0;
            y           <= '0;
            diff        <= 1'b0;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
            run_cnt     <= '0;
            first_frame <= 1'b1;
        end else if (enable) begin
            obj_code   <= code;
            diff       <= cell_diff;
            out_x      <= x;
            out_y      <= y;
            out_valid  <= 1'b1;
            frame_done <= last_cell;
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
            if (last_cell) begin
                diff_count  <= run_next;
                run_cnt     <= '0;
                first_frame <= 1'b0;
            end else begin
                run_cnt <= run_next;
            end
        end else begin
            diff       <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_diff_tracker.sv
// Directed bench for frame_diff_tracker at default size.
// A second instance with a 2-bit counter shares the stimulus.
module tb_frame_diff_tracker;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] obj_in;

    logic [3:0] x, y, out_x, out_y;
    logic [2:0] obj_code;
    logic       diff, out_valid, frame_done;
    logic [7:0] diff_count;

    logic [3:0] x2, y2, out_x2, out_y2;
    logic [2:0] obj_code2;
    logic       diff2, out_valid2, frame_done2;
    logic [1:0] diff_count2;

    int mode = 0;
    int checks = 0;
    int failures = 0;

    frame_diff_tracker dut (
        .clk(tb_clk), .rst(rst), .enable(enable), .clear(clear),
        .obj_in(obj_in), .x(x), .y(y), .obj_code(obj_code),
        .diff(diff), .out_valid(out_valid), .out_x(out_x),
        .out_y(out_y), .frame_done(frame_done),
        .diff_count(diff_count)
    );

    frame_diff_tracker #(.CNT_W(2)) dut2 (
        .clk(tb_clk), .rst(rst), .enable(enable), .clear(clear),
        .obj_in(obj_in), .x(x2), .y(y2), .obj_code(obj_code2),
        .diff(diff2), .out_valid(out_valid2), .out_x(out_x2),
        .out_y(out_y2), .frame_done(frame_done2),
        .diff_count(diff_count2)
    );

    always #5 tb_clk = ~tb_clk;

    function automatic bit is_border(int cx, int cy);
        return (cx == 0 || cx == 15 || cy == 0 || cy == 11);
    endfunction

    // Object flags presented for a cell in each test map.
    function automatic logic [3:0] stim(int m, int cx, int cy);
        case (m)
            1: begin
                if (is_border(cx, cy)) return 4'b1000;
                if (cx == 4 && cy == 4) return 4'b0001;
                if (cx == 6 && cy == 4) return 4'b0100;
                return 4'b0000;
            end
            2: begin
                if (is_border(cx, cy)) return 4'b1000;
                if (cx == 5 && cy == 4) return 4'b0001;
                if (cx == 4 && cy == 4) return 4'b0010;
                if (cx == 7 && cy == 4) return 4'b0100;
                return 4'b0000;
            end
            3: return 4'b0100;
            4: begin
                if (cx == 2 && cy == 2) return 4'b1001;
                if (cx == 3 && cy == 2) return 4'b0110;
                return stim(1, cx, cy);
            end
            default: return 4'b0000;
        endcase
    endfunction

    // Hand-written code table for each map.
    function automatic int exp_code(int m, int cx, int cy);
        case (m)
            1: begin
                if (is_border(cx, cy)) return 4;
                if (cx == 4 && cy == 4) return 1;
                if (cx == 6 && cy == 4) return 3;
                return 0;
            end
            2: begin
                if (is_border(cx, cy)) return 4;
                if (cx == 5 && cy == 4) return 1;
                if (cx == 4 && cy == 4) return 2;
                if (cx == 7 && cy == 4) return 3;
                return 0;
            end
            3: return 3;
            4: begin
                if (cx == 2 && cy == 2) return 4;
                if (cx == 3 && cy == 2) return 3;
                return exp_code(1, cx, cy);
            end
            default: return 0;
        endcase
    endfunction

    always_comb obj_in = stim(mode, int'(x), int'(y));

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int m, input int pm, input bit first,
                             input int exp_cnt, input int prev_cnt,
                             input int pause_at, input int stop_at);
        for (int i = 0; i < 192; i++) begin
            int cx = i % 16;
            int cy = i / 16;
            bit d = !first && (exp_code(m, cx, cy) != exp_code(pm, cx, cy));
            logic [13:0] ev;
            if (i == stop_at) return;
            if (i == pause_at) begin
                int px = (i - 1) % 16;
                int py = (i - 1) / 16;
                enable = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    cyc();
                    chk("pause_xy", 32'({x, y}), 32'({4'(cx), 4'(cy)}));
                    chk("pause_valid", 32'({out_valid, frame_done}), 32'd0);
                    chk("pause_hold", 32'({obj_code, out_x, out_y}),
                        32'({3'(exp_code(m, px, py)), 4'(px), 4'(py)}));
                end
                enable = 1'b1;
            end
            chk($sformatf("scan_m%0d_%0d_%0d", m, cx, cy),
                32'({x, y}), 32'({4'(cx), 4'(cy)}));
            cyc();
            ev = {1'b1, 4'(cx), 4'(cy), 3'(exp_code(m, cx, cy)),
                  d, (i == 191)};
            chk($sformatf("cell_m%0d_%0d_%0d", m, cx, cy),
                32'({out_valid, out_x, out_y, obj_code, diff, frame_done}),
                32'(ev));
            if (i == 100) begin
                chk("count_held", 32'(diff_count), 32'(prev_cnt));
            end
            if (i == 191) begin
                chk($sformatf("count_m%0d", m), 32'(diff_count),
                    32'(exp_cnt));
                chk($sformatf("count2_m%0d", m), 32'(diff_count2),
                    32'((exp_cnt > 3) ? 3 : exp_cnt));
            end
        end
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_xy", 32'({x, y}), 32'd0);
        chk("rst_code", 32'({obj_code, out_x, out_y}), 32'd0);
        chk("rst_flags", 32'({diff, out_valid, frame_done}), 32'd0);
        chk("rst_count", 32'(diff_count), 32'd0);
        chk("rst_count2", 32'(diff_count2), 32'd0);

        rst = 1'b0;
        enable = 1'b1;
        run_frame(0, 0, 1'b1, 0, 0, -1, 192);
        for (int k = 0; k < 8; k++) begin
            chk("wrap_xy", 32'({x, y}), 32'({4'(k), 4'd0}));
            cyc();
            chk("wrap_out",
                32'({out_valid, out_x, out_y, obj_code, diff, frame_done}),
                32'({1'b1, 4'(k), 4'd0, 3'd0, 1'b0, 1'b0}));
        end

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_state", 32'({x, y, out_valid, frame_done}), 32'd0);

        mode = 1;
        run_frame(1, 0, 1'b1, 0, 0, -1, 192);
        mode = 2;
        run_frame(2, 1, 1'b0, 4, 0, 55, 192);
        mode = 0;
        run_frame(0, 2, 1'b0, 55, 4, -1, 192);
        mode = 3;
        run_frame(3, 0, 1'b0, 192, 55, -1, 192);

        mode = 2;
        run_frame(2, 3, 1'b0, 0, 192, -1, 106);
        chk("pre_clear_xy", 32'({x, y}), 32'({4'd10, 4'd6}));
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_xy", 32'({x, y}), 32'd0);
        chk("clear_valid", 32'({out_valid, frame_done}), 32'd0);
        chk("clear_count", 32'(diff_count), 32'd192);
        chk("clear_count2", 32'(diff_count2), 32'd3);

        mode = 4;
        run_frame(4, 0, 1'b1, 0, 192, -1, 192);
        mode = 3;
        run_frame(3, 4, 1'b0, 190, 0, -1, 192);

        mode = 0;
        run_frame(0, 3, 1'b0, 0, 190, -1, 20);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_flags", 32'({out_valid, frame_done}), 32'd0);
        chk("midrst_count", 32'(diff_count), 32'd0);
        chk("midrst_count2", 32'(diff_count2), 32'd0);
        chk("midrst_xy", 32'({x, y}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_diff_tracker.md
Name: frame_diff_tracker

Overview:
- Parametrised successor to the fixed 16x12 frame tracker.
- Raster-scans a GRID_W x GRID_H cell grid and exposes the current scan address to the renderer/game logic.
- Priority-encodes NUM_OBJ one-hot object flags into an object code and stores a full previous frame on chip.
- Flags per-cell changes against that frame and reports a per-frame change count with a frame-done pulse, so downstream display logic redraws only changed cells.

Parameters:
- GRID_W, 16: cells per row (x range 0..GRID_W-1).
- GRID_H, 12: rows per frame (y range 0..GRID_H-1).
- NUM_OBJ, 4: number of object flag inputs; object i maps to code i+1; code 0 = empty.
- CODE_W, 3: object code width; must satisfy 2^CODE_W > NUM_OBJ.
- CNT_W, 8: width of the per-frame diff counter (saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance scan and process current cell when high
- clear  in  1  synchronous restart: scan to (0,0), next frame treated as first frame
- obj_in  in  NUM_OBJ  one-hot object flags for cell at (x,y); bit0 = head, bit1 = body, bit2 = apple, bit3 = border at default
- x  out  clog2(GRID_W)  current scan column
- y  out  clog2(GRID_H)  current scan row
- obj_code  out  CODE_W  registered code of last processed cell
- diff  out  1  registered: last processed cell differs from previous frame
- out_valid  out  1  obj_code/diff/out_x/out_y valid this cycle
- out_x  out  clog2(GRID_W)  column of the cell reported on obj_code
- out_y  out  clog2(GRID_H)  row of the cell reported on obj_code
- frame_done  out  1  one-cycle pulse when last cell of a frame is reported
- diff_count  out  CNT_W  number of diff cells in the completed frame, held until next frame_done

Behaviour:
- Reset (rst high at posedge clk) sets:
  - x, y, obj_code, out_x, out_y to 0.
  - diff, out_valid, frame_done to 0.
  - diff_count to 0; the internal running count to 0.
  - first_frame flag to 1.
- Frame memory contents are not reset; first_frame masks them.
- Scan order:
  - x increments every enabled cycle.
  - At x = GRID_W-1, x wraps to 0 and y increments.
  - At (GRID_W-1, GRID_H-1), both wrap to 0, first_frame clears, and the running count restarts.
- enable low:
  - x, y, and memory hold.
  - out_valid = 0 next cycle; obj_code/out_x/out_y hold their last value.
  - frame_done = 0.
- Encoding:
  - obj_in is sampled in the cycle x/y present the cell (combinational cell lookup by the driver).
  - Highest set index wins: code = (highest set bit index)+1.
  - obj_in = 0 gives code 0.
- Latency: one cycle. Values sampled at edge N appear on obj_code/diff/out_x/out_y after edge N with out_valid=1.
- Diff:
  - Old code is read from memory[y][x] in the same cycle; new code is written there at the same edge (read-before-write).
  - diff = (new != old) && !first_frame.
- Counting:
  - The running count increments on each diff cell and saturates at 2^CNT_W-1.
  - At the last cell, diff_count takes the final running count including that cell, and frame_done pulses together with that cell's out_valid.
  - Running count then restarts at 0.
- clear:
  - Takes effect like reset on x, y, first_frame, and the running count; the current cell is not written.
  - out_valid=0 next cycle; diff_count holds its last completed value.
  - clear has priority over enable.
- rst has priority over clear and enable. Mid-frame reset discards the partial frame: no frame_done, diff_count = 0.
- Memory is inferred as GRID_W*GRID_H x CODE_W registers/RAM with synchronous write. Address = y*GRID_W + x.

Test Plan:
- Reset, then hold enable=1, obj_in=0 for 200 cycles:
  - x,y step through (0,0)..(15,11) and wrap.
  - obj_code=0, diff=0 throughout.
  - frame_done pulses at cycle 192 with diff_count=0.
- Map1 at defaults:
  - Border ring of code 4, head(4,4)=1, apple(6,4)=3, rest 0.
  - First frame: obj_code matches map at each out_x/out_y, diff=0 everywhere.
- Second frame Map2: head(5,4), body(4,4), apple(7,4):
  - diff=1 at (4,4), (5,4), (6,4), (7,4) only; diff=0 on border.
  - diff_count=4 at frame_done.
- Priority:
  - obj_in=4'b1001 at some cell gives obj_code=4.
  - obj_in=4'b0110 gives obj_code=3.
- enable toggled 0 for 5 cycles mid-row at (7,3): x,y hold, out_valid=0; resumes at (7,3) with no skipped or duplicated cell.
- clear asserted at (10,6) during frame 2: scan restarts at (0,0), next frame reports diff=0 everywhere, and diff_count keeps frame-1 value until that frame's frame_done.
- CNT_W=2, change all 192 cells: diff_count saturates at 3.
